// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier for MIPS MULT.
// One Booth step per clock; the 2*WIDTH-bit product feeds the HI/LO pair
// (result[2*WIDTH-1:WIDTH] -> HI, result[WIDTH-1:0] -> LO).
//
// Handshake: start is a request that is only sampled while the block is idle
// (busy=0, done=0); a start seen in any other cycle is dropped, not queued.
// busy is high for exactly the WIDTH cycles of iteration. done is a single
// cycle pulse the cycle after the last step, marking result as freshly
// updated. result is held between completions, so the control unit may read
// it at any time after the done pulse.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Counter wide enough to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Booth datapath registers. acc carries one extra bit so that acc - m
  // cannot overflow when the multiplicand is the most negative value.
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    cnt;

  // Combinational results of one Booth step.
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_shf;
  logic [WIDTH-1:0] q_shf;
  logic             last_step;

  assign state_dbg = state;
  assign last_step = (cnt == CW'(1));

  // One Booth step: conditional add/subtract, then arithmetic right shift
  // of the combined {acc, q, q_1} register.
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_1})
      2'b01:   acc_sum = acc + m;
      2'b10:   acc_sum = acc - m;
      default: acc_sum = acc;
    endcase
    acc_shf = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_shf   = {acc_sum[0], q[WIDTH-1:1]};
  end

  // Next-state logic: accept in IDLE, iterate WIDTH steps, pulse DONE once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand capture, Booth iteration and result update on the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= {a[WIDTH-1], a};
            q   <= b;
            acc <= '0;
            q_1 <= 1'b0;
            cnt <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc <= acc_shf;
          q   <= q_shf;
          q_1 <= q[0];
          cnt <= cnt - CW'(1);
          if (last_step) begin
            // The low 2*WIDTH bits of {acc, q} are the exact signed product.
            result <= {acc_shf[WIDTH-1:0], q_shf};
          end
        end
        default: begin
          // DONE: hold everything; the next accept reloads the datapath.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corner cases, start
// collision, asynchronous reset abort, and a randomized run against an
// arithmetic reference product.
module tb_booth_multiplier;

  localparam int W = 32;

  // Clock / reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic [2*W-1:0] result;
  logic           done;
  logic           busy;
  logic [1:0]     state_dbg;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .start     (start),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Scoreboard state
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_exp;
  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int accepted   = 0;

  // Count every done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference: exact signed product via plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
  endfunction

  // Operand picker biased toward corner values.
  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0:       v = '0;
      1:       v = W'(1);
      2:       v = '1;
      3:       v = {1'b1, {(W-1){1'b0}}};
      4:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with start high for one cycle, wait for done, check
  // latency, product and the single-cycle pulse.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp, input bit chk_busy,
                        input bit scramble);
    int n;
    logic [2*W-1:0] e;
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(exp);
    accepted++;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (chk_busy) begin
        check("busy_in_run", {63'd0, busy}, 64'd1);
        check("no_early_done", {63'd0, done}, 64'd0);
      end
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd33);
    e = exp_q.pop_front();
    last_exp = e;
    check("result", result, e);
    check("busy_low_in_done", {63'd0, busy}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("busy_low_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    int gap;
    logic [W-1:0] x;
    logic [W-1:0] y;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    last_exp = '0;

    // Reset state
    #12;
    check("reset_result", result, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();
    tick();

    // Basic product with busy window and latency
    run_op(W'(3), W'(5), 64'h0000_0000_0000_000F, 1'b1, 1'b0);

    // Sign handling
    run_op(32'hFFFF_FFFF, W'(1), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op(-W'(7), -W'(6), 64'd42, 1'b0, 1'b1);

    // Extremes
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0, 1'b0);
    run_op(W'(0), 32'h8000_0000, 64'd0, 1'b0, 1'b0);

    // start during RUN is ignored and operands are captured at accept
    a = W'(6);
    b = W'(7);
    start = 1'b1;
    exp_q.push_back(64'd42);
    accepted++;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a = W'(9);
    b = W'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 6;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("collide_latency", 64'(n), 64'd33);
    check("collide_result", result, exp_q.pop_front());
    tick();
    check("collide_single_done", {63'd0, done}, 64'd0);
    tick();
    check("collide_no_second_done", {63'd0, done}, 64'd0);
    check("collide_idle", {63'd0, busy}, 64'd0);
    run_op(W'(9), W'(9), 64'd81, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    a = W'(123);
    b = W'(456);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", result, 64'd0);
    #2;
    reset = 1'b0;
    tick();
    check("abort_still_idle", {63'd0, busy}, 64'd0);
    run_op(W'(2), -W'(3), 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);

    // Randomized operations with idle gaps; result must hold while idle
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        a = W'($urandom);
        b = W'($urandom);
        check("idle_hold", result, last_exp);
        tick();
      end
      x = pick();
      y = pick();
      run_op(x, y, ref_mul(x, y), 1'b0, 1'b1);
    end

    tick();
    tick();
    check("done_count", 64'(done_cnt), 64'(accepted));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
